temp_calib_monitor: RTL and testbench
=====================================

# temp_calib_monitor

Parametrised multi-channel temperature calibration and range monitor. Accepts raw sensor samples tagged with a channel number, applies a per-channel fixed-point gain and bias, and runs a per-channel debounced, hysteretic high/low alarm state machine on the calibrated result. It sits between the sensor capture logic and system supervision. It replaces ad-hoc range checks on single gain/bias-corrected readings with synthesisable, per-channel alarm hardware.

## Interface
Parameters:
- CHANNELS, 4, number of sensor channels (≥1); CH_W = max(1, $clog2(CHANNELS))
- IN_W, 8, raw sample width, unsigned
- GAIN_W, 8, gain width, unsigned fixed point
- FRAC_BITS, 4, fractional bits of gain
- BIAS_W, 8, bias width, unsigned
- OUT_W, 16, calibrated output width
- HI_LIMIT, 180, high alarm threshold
- LO_LIMIT, 20, low alarm threshold
- HYST, 4, hysteresis for alarm exit
- DEBOUNCE, 3, consecutive out-of-range samples required to raise an alarm (≥1)

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  raw sample present this cycle
- sample_ch  in  CH_W  channel of the sample; values ≥ CHANNELS are dropped
- sample_data  in  IN_W  raw sensor value
- cfg_we  in  1  write gain/bias for cfg_ch
- cfg_ch  in  CH_W  configuration channel
- cfg_gain  in  GAIN_W  new gain
- cfg_bias  in  BIAS_W  new bias
- alarm_clear  in  CHANNELS  per-channel sticky clear (used only with TEMP_MON_STICKY_EN)
- cal_valid  out  1  calibrated result valid
- cal_ch  out  CH_W  channel of result
- cal_data  out  OUT_W  calibrated, saturated value
- alarm_hi  out  CHANNELS  per-channel high alarm
- alarm_lo  out  CHANNELS  per-channel low alarm

## Operation
- Arithmetic is unsigned: cal = ((raw × gain) >> FRAC_BITS) + bias, computed at full width (IN_W+GAIN_W+1). The result saturates to 2^OUT_W−1 on overflow.
- Gain and bias registers exist per channel. On reset, gain = 1<<FRAC_BITS and bias = 0.
- cfg_we updates the registers on the clock edge. A sample of the same channel in the same cycle uses the old values.
- Each channel has a state machine with states NORMAL, HIGH and LOW, plus a debounce counter (reset to NORMAL, count 0). It is evaluated only on cal_valid for that channel:
  - NORMAL: if cal > HI_LIMIT, the high count increments and the low count clears. If cal < LO_LIMIT, the reverse applies. Otherwise both counts clear. The state goes to HIGH or LOW when the respective count reaches DEBOUNCE; the counts then clear.
  - HIGH: goes to NORMAL when cal ≤ HI_LIMIT−HYST. If cal < LO_LIMIT, it goes to NORMAL with the low count set to 1.
  - LOW: goes to NORMAL when cal ≥ LO_LIMIT+HYST. The symmetric rule applies for cal > HI_LIMIT.
- Samples for other channels do not affect a channel's counters.
- Every valid sample is accepted. There is no backpressure.

## Timing
- Pipeline is two stages: multiply, then shift/add/saturate. cal_valid, cal_ch and cal_data are registered and appear exactly 2 cycles after sample_valid.
- Throughput is one sample per cycle, any channel order.
- alarm_hi and alarm_lo are registered. They change 1 cycle after the cal_valid that triggers the state change, i.e. 3 cycles after the sample.
- Reset values: cal_valid=0, cal_ch=0, cal_data=0, alarm_hi=0, alarm_lo=0.
- Reset asserted mid-operation flushes in-flight samples (no cal_valid) and returns every channel to NORMAL with count 0.

## Configuration
- TEMP_MON_STICKY_EN defined:
  - An alarm bit, once set, stays 1 after the state returns to NORMAL.
  - It clears 1 cycle after alarm_clear[ch]=1, provided the channel state is not HIGH/LOW that cycle.
  - Set wins over a simultaneous clear.
- TEMP_MON_STICKY_EN undefined:
  - alarm_hi[ch] = (state==HIGH) and alarm_lo[ch] = (state==LOW), both registered.
  - alarm_clear is ignored.

## Test plan
- Defaults after reset, ch0 raw=50 → cal_data=50 (0x0032), cal_ch=0, 2 cycles later; alarms 0.
- cfg ch1 gain=0x20 (2.0), bias=10; ch1 raw=90 → cal_data=190. Three consecutive such samples → alarm_hi[1]=1 3 cycles after the third. Then raw=80 (cal 170) → alarm_hi[1]=0 (without macro), or stays 1 until alarm_clear[1] (with macro).
- Hysteresis: ch2 in HIGH, cal=178 (≤180 but >176) → stays HIGH; cal=176 → NORMAL.
- Debounce interleave: ch3 raw=10, 10, then a ch0 sample, then ch3 raw=10 → alarm_lo[3]=1. Ch3 raw=10, 10, 30, 10 → no alarm.
- Saturation: OUT_W=8, gain=0xFF, raw=0xFF, bias=0xFF → cal_data=0xFF. Same-cycle cfg_we and sample on ch0 → old gain used.
- Reset asserted 1 cycle after sample_valid → no cal_valid; all alarms 0 immediately.

Source files
------------

// File: rtl/temp_calib_monitor.sv
// Multi-channel temperature calibration (gain/bias, saturating) with per-channel
// debounced, hysteretic high/low alarms. Define TEMP_MON_STICKY_EN for sticky alarm bits.
module temp_calib_monitor #(
    parameter int CHANNELS  = 4,
    parameter int IN_W      = 8,
    parameter int GAIN_W    = 8,
    parameter int FRAC_BITS = 4,
    parameter int BIAS_W    = 8,
    parameter int OUT_W     = 16,
    parameter int HI_LIMIT  = 180,
    parameter int LO_LIMIT  = 20,
    parameter int HYST      = 4,
    parameter int DEBOUNCE  = 3,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [CH_W-1:0]     sample_ch,
    input  logic [IN_W-1:0]     sample_data,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [GAIN_W-1:0]   cfg_gain,
    input  logic [BIAS_W-1:0]   cfg_bias,
    input  logic [CHANNELS-1:0] alarm_clear,
    output logic                cal_valid,
    output logic [CH_W-1:0]     cal_ch,
    output logic [OUT_W-1:0]    cal_data,
    output logic [CHANNELS-1:0] alarm_hi,
    output logic [CHANNELS-1:0] alarm_lo
);

    localparam int PROD_W = IN_W + GAIN_W;
    localparam int SUM_W  = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + 1;
    localparam int WIDE_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    localparam logic [WIDE_W-1:0] SAT_MAX  = WIDE_W'({OUT_W{1'b1}});
    localparam logic [OUT_W-1:0]  HI_TH    = OUT_W'(HI_LIMIT);
    localparam logic [OUT_W-1:0]  LO_TH    = OUT_W'(LO_LIMIT);
    localparam logic [OUT_W-1:0]  HI_EXIT  = OUT_W'(HI_LIMIT - HYST);
    localparam logic [OUT_W-1:0]  LO_EXIT  = OUT_W'(LO_LIMIT + HYST);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic [GAIN_W-1:0] gain_q [CHANNELS];
    logic [BIAS_W-1:0] bias_q [CHANNELS];

    logic [GAIN_W-1:0] gain_sel;
    logic [BIAS_W-1:0] bias_sel;
    logic              ch_ok;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [PROD_W-1:0] s1_prod;
    logic [BIAS_W-1:0] s1_bias;

    logic [WIDE_W-1:0] wide_sum;
    logic [OUT_W-1:0]  sat_data;

    state_t            state_q [CHANNELS];
    state_t            state_d [CHANNELS];
    logic [CNT_W-1:0]  hi_cnt_q [CHANNELS];
    logic [CNT_W-1:0]  hi_cnt_d [CHANNELS];
    logic [CNT_W-1:0]  lo_cnt_q [CHANNELS];
    logic [CNT_W-1:0]  lo_cnt_d [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                gain_q[i] <= GAIN_W'(1 << FRAC_BITS);
                bias_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (cfg_we && cfg_ch == CH_W'(i)) begin
                    gain_q[i] <= cfg_gain;
                    bias_q[i] <= cfg_bias;
                end
            end
        end
    end

    // Channel decode doubles as the range check: unmatched channel numbers are dropped.
    always_comb begin
        gain_sel = '0;
        bias_sel = '0;
        ch_ok    = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sample_ch == CH_W'(i)) begin
                gain_sel = gain_q[i];
                bias_sel = bias_q[i];
                ch_ok    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_prod  <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= sample_valid && ch_ok;
            s1_ch    <= sample_ch;
            s1_prod  <= PROD_W'(sample_data) * PROD_W'(gain_sel);
            s1_bias  <= bias_sel;
        end
    end

    always_comb begin
        wide_sum = WIDE_W'(s1_prod >> FRAC_BITS) + WIDE_W'(s1_bias);
        sat_data = (wide_sum > SAT_MAX) ? '1 : OUT_W'(wide_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_valid <= 1'b0;
            cal_ch    <= '0;
            cal_data  <= '0;
        end else begin
            cal_valid <= s1_valid;
            cal_ch    <= s1_ch;
            cal_data  <= sat_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= ST_NORMAL;
                hi_cnt_q[i] <= '0;
                lo_cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            hi_cnt_d[i] = hi_cnt_q[i];
            lo_cnt_d[i] = lo_cnt_q[i];
            if (cal_valid && cal_ch == CH_W'(i)) begin
                case (state_q[i])
                    ST_NORMAL: begin
                        if (cal_data > HI_TH) begin
                            lo_cnt_d[i] = '0;
                            if (hi_cnt_q[i] >= CNT_LAST) begin
                                state_d[i]  = ST_HIGH;
                                hi_cnt_d[i] = '0;
                            end else begin
                                hi_cnt_d[i] = hi_cnt_q[i] + CNT_W'(1);
                            end
                        end else if (cal_data < LO_TH) begin
                            hi_cnt_d[i] = '0;
                            if (lo_cnt_q[i] >= CNT_LAST) begin
                                state_d[i]  = ST_LOW;
                                lo_cnt_d[i] = '0;
                            end else begin
                                lo_cnt_d[i] = lo_cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            hi_cnt_d[i] = '0;
                            lo_cnt_d[i] = '0;
                        end
                    end
                    // A direct swing to the opposite limit counts as its first out-of-range sample.
                    ST_HIGH: begin
                        if (cal_data < LO_TH) begin
                            state_d[i]  = ST_NORMAL;
                            hi_cnt_d[i] = '0;
                            lo_cnt_d[i] = CNT_W'(1);
                        end else if (cal_data <= HI_EXIT) begin
                            state_d[i]  = ST_NORMAL;
                            hi_cnt_d[i] = '0;
                            lo_cnt_d[i] = '0;
                        end
                    end
                    ST_LOW: begin
                        if (cal_data > HI_TH) begin
                            state_d[i]  = ST_NORMAL;
                            hi_cnt_d[i] = CNT_W'(1);
                            lo_cnt_d[i] = '0;
                        end else if (cal_data >= LO_EXIT) begin
                            state_d[i]  = ST_NORMAL;
                            hi_cnt_d[i] = '0;
                            lo_cnt_d[i] = '0;
                        end
                    end
                    default: begin
                        state_d[i]  = ST_NORMAL;
                        hi_cnt_d[i] = '0;
                        lo_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Alarm bits are registered from the next state so they track the state register.
`ifdef TEMP_MON_STICKY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_hi <= '0;
            alarm_lo <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                alarm_hi[i] <= (state_d[i] == ST_HIGH) ||
                               (alarm_hi[i] && !(alarm_clear[i] && state_q[i] == ST_NORMAL));
                alarm_lo[i] <= (state_d[i] == ST_LOW) ||
                               (alarm_lo[i] && !(alarm_clear[i] && state_q[i] == ST_NORMAL));
            end
        end
    end
`else
    logic clear_unused;
    assign clear_unused = ^alarm_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_hi <= '0;
            alarm_lo <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                alarm_hi[i] <= (state_d[i] == ST_HIGH);
                alarm_lo[i] <= (state_d[i] == ST_LOW);
            end
        end
    end
`endif

endmodule

// File: tb/tb_temp_calib_monitor.sv
// Scoreboard bench for temp_calib_monitor: random and directed samples checked
// against a behavioural model; a second narrow instance covers saturation and channel drop.
module tb_temp_calib_monitor;

    localparam int CHANNELS  = 4;
    localparam int IN_W      = 8;
    localparam int GAIN_W    = 8;
    localparam int FRAC_BITS = 4;
    localparam int BIAS_W    = 8;
    localparam int OUT_W     = 16;
    localparam int HI_LIMIT  = 180;
    localparam int LO_LIMIT  = 20;
    localparam int HYST      = 4;
    localparam int DEBOUNCE  = 3;
    localparam int CH_W      = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic [CH_W-1:0]     sample_ch;
    logic [IN_W-1:0]     sample_data;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [GAIN_W-1:0]   cfg_gain;
    logic [BIAS_W-1:0]   cfg_bias;
    logic [CHANNELS-1:0] alarm_clear;
    logic                cal_valid;
    logic [CH_W-1:0]     cal_ch;
    logic [OUT_W-1:0]    cal_data;
    logic [CHANNELS-1:0] alarm_hi;
    logic [CHANNELS-1:0] alarm_lo;

    logic       s_valid;
    logic [1:0] s_ch;
    logic [7:0] s_data;
    logic       s_we;
    logic [1:0] s_cch;
    logic [7:0] s_gain;
    logic [7:0] s_bias;
    logic [2:0] s_clear;
    logic       s_cal_valid;
    logic [1:0] s_cal_ch;
    logic [7:0] s_cal_data;
    logic [2:0] s_hi;
    logic [2:0] s_lo;

    temp_calib_monitor #(
        .CHANNELS(CHANNELS), .IN_W(IN_W), .GAIN_W(GAIN_W), .FRAC_BITS(FRAC_BITS),
        .BIAS_W(BIAS_W), .OUT_W(OUT_W), .HI_LIMIT(HI_LIMIT), .LO_LIMIT(LO_LIMIT),
        .HYST(HYST), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain),
        .cfg_bias(cfg_bias), .alarm_clear(alarm_clear), .cal_valid(cal_valid),
        .cal_ch(cal_ch), .cal_data(cal_data), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo)
    );

    temp_calib_monitor #(
        .CHANNELS(3), .OUT_W(8)
    ) dut_sat (
        .clk(clk), .reset(reset), .sample_valid(s_valid), .sample_ch(s_ch),
        .sample_data(s_data), .cfg_we(s_we), .cfg_ch(s_cch), .cfg_gain(s_gain),
        .cfg_bias(s_bias), .alarm_clear(s_clear), .cal_valid(s_cal_valid),
        .cal_ch(s_cal_ch), .cal_data(s_cal_data), .alarm_hi(s_hi), .alarm_lo(s_lo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          ch;
        longint      data;
        int          at;
        logic [3:0]  hi;
        logic [3:0]  lo;
    } exp_t;

    exp_t sb[$];

    int         m_gain [CHANNELS];
    int         m_bias [CHANNELS];
    int         m_st   [CHANNELS];   // 0 normal, 1 high, 2 low
    int         m_hc   [CHANNELS];
    int         m_lc   [CHANNELS];
    logic [3:0] m_hi;
    logic [3:0] m_lo;

    bit         alarm_pending = 1'b0;
    logic [3:0] pend_hi;
    logic [3:0] pend_lo;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint calc(input int raw, input int g, input int b, input int ow);
        longint v;
        longint mx;
        v  = ((longint'(raw) * longint'(g)) >> FRAC_BITS) + longint'(b);
        mx = (longint'(1) << ow) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            m_gain[i] = 1 << FRAC_BITS;
            m_bias[i] = 0;
            m_st[i]   = 0;
            m_hc[i]   = 0;
            m_lc[i]   = 0;
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic model_eval(input int ch, input longint cal);
        case (m_st[ch])
            0: begin
                if (cal > HI_LIMIT) begin
                    m_lc[ch] = 0;
                    m_hc[ch] = m_hc[ch] + 1;
                    if (m_hc[ch] >= DEBOUNCE) begin m_st[ch] = 1; m_hc[ch] = 0; end
                end else if (cal < LO_LIMIT) begin
                    m_hc[ch] = 0;
                    m_lc[ch] = m_lc[ch] + 1;
                    if (m_lc[ch] >= DEBOUNCE) begin m_st[ch] = 2; m_lc[ch] = 0; end
                end else begin
                    m_hc[ch] = 0;
                    m_lc[ch] = 0;
                end
            end
            1: begin
                if (cal < LO_LIMIT) begin m_st[ch] = 0; m_hc[ch] = 0; m_lc[ch] = 1; end
                else if (cal <= HI_LIMIT - HYST) begin m_st[ch] = 0; m_hc[ch] = 0; m_lc[ch] = 0; end
            end
            default: begin
                if (cal > HI_LIMIT) begin m_st[ch] = 0; m_hc[ch] = 1; m_lc[ch] = 0; end
                else if (cal >= LO_LIMIT + HYST) begin m_st[ch] = 0; m_hc[ch] = 0; m_lc[ch] = 0; end
            end
        endcase
`ifdef TEMP_MON_STICKY_EN
        m_hi[ch] = m_hi[ch] | (m_st[ch] == 1);
        m_lo[ch] = m_lo[ch] | (m_st[ch] == 2);
`else
        m_hi[ch] = (m_st[ch] == 1);
        m_lo[ch] = (m_st[ch] == 2);
`endif
    endtask

    // One stimulus cycle on the main instance; expected result pushed with its arrival cycle.
    task automatic step(input bit v, input int ch, input int raw,
                        input bit we, input int cch, input int g, input int b);
        exp_t e;
        @(negedge clk);
        sample_valid = v;
        sample_ch    = CH_W'(ch);
        sample_data  = IN_W'(raw);
        cfg_we       = we;
        cfg_ch       = CH_W'(cch);
        cfg_gain     = GAIN_W'(g);
        cfg_bias     = BIAS_W'(b);
        if (v) begin
            e.ch   = ch;
            e.data = calc(raw, m_gain[ch], m_bias[ch], OUT_W);
            model_eval(ch, e.data);
            e.at   = cyc + 2;
            e.hi   = m_hi;
            e.lo   = m_lo;
            sb.push_back(e);
        end
        if (we) begin
            m_gain[cch] = g;
            m_bias[cch] = b;
        end
    endtask

    task automatic smp(input int ch, input int raw);
        step(1'b1, ch, raw, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (alarm_pending) begin
            chk("alarm_hi", longint'(alarm_hi), longint'(pend_hi));
            chk("alarm_lo", longint'(alarm_lo), longint'(pend_lo));
            alarm_pending = 1'b0;
        end
        if (cal_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_cal_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("cal_ch", longint'(cal_ch), longint'(e.ch));
                chk("cal_data", longint'(cal_data), e.data);
                chk("latency_cycle", longint'(cyc), longint'(e.at));
                pend_hi       = e.hi;
                pend_lo       = e.lo;
                alarm_pending = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int wait_cnt;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample_data  = '0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_gain     = '0;
        cfg_bias     = '0;
        alarm_clear  = '0;
        s_valid = 1'b0; s_ch = '0; s_data = '0; s_we = 1'b0;
        s_cch = '0; s_gain = '0; s_bias = '0; s_clear = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_cal_valid", longint'(cal_valid), 0);
        chk("reset_cal_ch", longint'(cal_ch), 0);
        chk("reset_cal_data", longint'(cal_data), 0);
        chk("reset_alarm_hi", longint'(alarm_hi), 0);
        chk("reset_alarm_lo", longint'(alarm_lo), 0);

        // Narrow instance: same-cycle cfg uses old gain, then saturation, then dropped channel 3.
        s_valid = 1'b1; s_ch = 2'd0; s_data = 8'd100;
        s_we = 1'b1; s_cch = 2'd0; s_gain = 8'hFF; s_bias = 8'hFF;
        @(negedge clk);
        s_we = 1'b0; s_data = 8'hFF;
        @(negedge clk);
        s_ch = 2'd3; s_data = 8'd5;
        chk("sat_old_gain_valid", longint'(s_cal_valid), 1);
        chk("sat_old_gain_data", longint'(s_cal_data), 100);
        @(negedge clk);
        s_valid = 1'b0;
        chk("sat_valid", longint'(s_cal_valid), 1);
        chk("sat_data", longint'(s_cal_data), 255);
        chk("sat_ch", longint'(s_cal_ch), 0);
        @(negedge clk);
        chk("dropped_ch_valid", longint'(s_cal_valid), 0);

        // Directed: defaults, ch1 gain 2.0 alarm, hysteresis on ch2, debounce interleave on ch3.
        smp(0, 50);
        step(1'b0, 0, 0, 1'b1, 1, 32, 10);
        repeat (3) smp(1, 90);
        idle(3);
        smp(1, 80);
        idle(3);
        repeat (3) smp(2, 181);
        idle(2);
        smp(2, 178);
        idle(2);
        smp(2, 176);
        idle(3);
        smp(3, 10); smp(3, 10); smp(0, 50); smp(3, 10);
        idle(3);
        smp(3, 24);
        smp(3, 10); smp(3, 10); smp(3, 30); smp(3, 10);
        idle(3);
        step(1'b1, 0, 50, 1'b1, 0, 48, 0);
        smp(0, 50);
        idle(3);
        smp(2, 200); smp(2, 5); smp(2, 200); smp(2, 200);
        idle(4);

        // Reset one cycle after a sample: flushes it and clears alarms immediately.
        repeat (3) smp(0, 200);
        repeat (3) smp(3, 5);
        idle(4);
        smp(2, 100);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        alarm_pending = 1'b0;
        model_reset();
        #1;
        chk("midreset_alarm_hi", longint'(alarm_hi), 0);
        chk("midreset_alarm_lo", longint'(alarm_lo), 0);
        chk("midreset_cal_valid", longint'(cal_valid), 0);
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        chk("post_reset_cal_valid", longint'(cal_valid), 0);

        // Random traffic with occasional reconfiguration.
        for (int n = 0; n < 1500; n++) begin
            int ch, raw, sel, g;
            bit v, we;
            v   = ($urandom % 4) != 0;
            ch  = $urandom % CHANNELS;
            sel = $urandom % 4;
            case (sel)
                0:       raw = $urandom_range(0, 30);
                1:       raw = $urandom_range(160, 200);
                2:       raw = $urandom_range(14, 26);
                default: raw = $urandom % 256;
            endcase
            we = ($urandom % 20) == 0;
            case ($urandom % 5)
                0:       g = 8;
                1:       g = 32;
                2:       g = $urandom % 256;
                default: g = 16;
            endcase
            step(v, ch, raw, we, $urandom % CHANNELS, g, $urandom_range(0, 40));
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            idle(1);
            wait_cnt++;
        end
        idle(2);
        chk("scoreboard_drained", longint'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
